// File: rtl/uart_pixel_framer_if.sv
// Byte-in / pixel-out handshake bundle for uart_pixel_framer.
// slave = framer side, master = source/sink side (UART bridge + vision pipeline).
interface uart_pixel_framer_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] pixel_o;
  logic       valid_o;
  logic       ready_i;
  logic       sof_o;
  logic       eol_o;
  logic       frame_done_o;
  logic       err_o;
  logic       busy_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, pixel_o, valid_o, sof_o, eol_o, frame_done_o, err_o, busy_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, pixel_o, valid_o, sof_o, eol_o, frame_done_o, err_o, busy_o
  );
endinterface

// File: rtl/uart_pixel_framer.sv
// Parses SYNC/WIDTH/HEIGHT-framed UART bytes into a pixel stream with sof/eol and a stall watchdog.
// Optional trailing XOR checksum byte enabled by defining FRAMER_CHECKSUM_EN.
module uart_pixel_framer #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 25_000_000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  uart_pixel_framer_if.slave bus
);
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] WIDTH   = 3'd1;
  localparam logic [2:0] HEIGHT  = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
`ifdef FRAMER_CHECKSUM_EN
  localparam logic [2:0] CHECK   = 3'd4;
  logic [7:0]      xor_reg;
`endif

  logic [2:0]      state_reg;
  logic [7:0]      width_m1_reg;
  logic [7:0]      height_m1_reg;
  logic [7:0]      col_reg;
  logic [7:0]      row_reg;
  logic [WD_W-1:0] wd_reg;
  logic [7:0]      pixel_reg;
  logic            valid_reg;
  logic            sof_reg;
  logic            eol_reg;
  logic            done_reg;
  logic            err_reg;

  logic ready;
  logic accept;
  logic load;
  logic expire;

  always_comb begin
    ready  = (state_reg == PAYLOAD) ? (!valid_reg || bus.ready_i) : 1'b1;
    accept = bus.valid_i && ready;
    load   = accept && (state_reg == PAYLOAD);
    // An accept on the expiry cycle wins over the timeout.
    expire = (state_reg != HUNT) && !accept && (wd_reg == WD_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg     <= HUNT;
      width_m1_reg  <= 8'd0;
      height_m1_reg <= 8'd0;
      col_reg       <= 8'd0;
      row_reg       <= 8'd0;
      wd_reg        <= '0;
      pixel_reg     <= 8'd0;
      valid_reg     <= 1'b0;
      sof_reg       <= 1'b0;
      eol_reg       <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;

      if (state_reg == HUNT || accept || expire) wd_reg <= '0;
      else                                        wd_reg <= wd_reg + WD_W'(1);

      // Output register is independent of the FSM so a pending beat survives an abort.
      if (load) begin
        pixel_reg <= bus.data_i;
        valid_reg <= 1'b1;
        sof_reg   <= (col_reg == 8'd0) && (row_reg == 8'd0);
        eol_reg   <= (col_reg == width_m1_reg);
      end else if (bus.ready_i) begin
        valid_reg <= 1'b0;
      end

      if (expire) begin
        state_reg <= HUNT;
        err_reg   <= 1'b1;
      end else if (accept) begin
        case (state_reg)
          HUNT: begin
            if (bus.data_i == SYNC_BYTE) begin
              state_reg <= WIDTH;
              col_reg   <= 8'd0;
              row_reg   <= 8'd0;
            end
          end
          WIDTH: begin
            if (bus.data_i == 8'd0) begin
              state_reg <= HUNT;
              err_reg   <= 1'b1;
            end else begin
              width_m1_reg <= bus.data_i - 8'd1;
              state_reg    <= HEIGHT;
            end
          end
          HEIGHT: begin
            if (bus.data_i == 8'd0) begin
              state_reg <= HUNT;
              err_reg   <= 1'b1;
            end else begin
              height_m1_reg <= bus.data_i - 8'd1;
              state_reg     <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            if (col_reg == width_m1_reg) begin
              col_reg <= 8'd0;
              if (row_reg == height_m1_reg) begin
`ifdef FRAMER_CHECKSUM_EN
                state_reg <= CHECK;
`else
                state_reg <= HUNT;
                done_reg  <= 1'b1;
`endif
              end else begin
                row_reg <= row_reg + 8'd1;
              end
            end else begin
              col_reg <= col_reg + 8'd1;
            end
          end
`ifdef FRAMER_CHECKSUM_EN
          CHECK: begin
            state_reg <= HUNT;
            if (bus.data_i == xor_reg) done_reg <= 1'b1;
            else                       err_reg  <= 1'b1;
          end
`endif
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

`ifdef FRAMER_CHECKSUM_EN
  // Running XOR over WIDTH, HEIGHT and pixels; cleared by the sync byte.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      xor_reg <= 8'd0;
    end else if (accept) begin
      if (state_reg == HUNT) xor_reg <= 8'd0;
      else                   xor_reg <= xor_reg ^ bus.data_i;
    end
  end
`endif

  assign bus.ready_o      = ready;
  assign bus.pixel_o      = pixel_reg;
  assign bus.valid_o      = valid_reg;
  assign bus.sof_o        = sof_reg;
  assign bus.eol_o        = eol_reg;
  assign bus.frame_done_o = done_reg;
  assign bus.err_o        = err_reg;
  assign bus.busy_o       = (state_reg != HUNT);
endmodule
